// File: rtl/io_pmp_burst_check.sv
// Sequential IO-PMP checker for AXI bursts: one descriptor in, scan PMP entries
// lowest index first checking the burst's first and last byte, allow/deny out.

module pmp_entry #(
  parameter int unsigned PLEN           = 56,
  parameter int unsigned PMP_LEN        = 54,
  parameter int unsigned PMPGranularity = 0
) (
  input  logic [PLEN-1:0]    addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_prev_i,
  input  logic [1:0]         conf_addr_mode_i,
  output logic               match_o
);
  localparam int unsigned AW   = (PMP_LEN + 2 > PLEN) ? PMP_LEN + 2 : PLEN;
  localparam int unsigned NLOW = (PMPGranularity < 2) ? 2 : PMPGranularity + 1;
  localparam logic [AW-1:0] TOR_MASK  = ~((AW'(1) << (PMPGranularity + 2)) - AW'(1));
  localparam logic [AW-1:0] NAPOT_LOW = (AW'(1) << NLOW) - AW'(1);

  logic [AW-1:0] a;
  logic [AW-1:0] base;
  logic [AW-1:0] prev;
  logic [AW-1:0] napot;
  logic [AW-1:0] napot_care;

  // Address-range match for the selected mode; x^(x+1) exposes the NAPOT size bits.
  always_comb begin
    a          = AW'(addr_i);
    base       = AW'({conf_addr_i, 2'b00});
    prev       = AW'({conf_addr_prev_i, 2'b00});
    napot      = base | NAPOT_LOW;
    napot_care = ~(napot ^ (napot + AW'(1)));
    case (conf_addr_mode_i)
      2'b01: match_o = (a >= (prev & TOR_MASK)) && (a < (base & TOR_MASK));
      2'b10: begin
        if (PMPGranularity == 0) begin
          match_o = (a[AW-1:2] == base[AW-1:2]);
        end else begin
          match_o = 1'b0;
        end
      end
      2'b11: match_o = (((a ^ napot) & napot_care) == '0);
      default: match_o = 1'b0;
    endcase
  end
endmodule

module io_pmp_burst_check #(
  parameter int unsigned PLEN           = 56,
  parameter int unsigned PMP_LEN        = 54,
  parameter int unsigned NR_ENTRIES     = 16,
  parameter int unsigned PMPGranularity = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [PLEN-1:0]                       req_addr_i,
  input  logic [7:0]                            req_len_i,
  input  logic [2:0]                            req_size_i,
  input  logic [1:0]                            req_burst_i,
  input  logic                                  req_write_i,
  input  logic [1:0]                            priv_lvl_i,
  input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]    conf_addr_i,
  input  logic [NR_ENTRIES-1:0][7:0]            conf_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic                                  rsp_allow_o,
  output logic                                  rsp_hit_o,
  output logic [$clog2(NR_ENTRIES)-1:0]         rsp_entry_o
);
  localparam int unsigned IW = $clog2(NR_ENTRIES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]                         state;
  logic [IW-1:0]                      idx;
  logic [PLEN-1:0]                    addr;
  logic [7:0]                         len;
  logic [2:0]                         size;
  logic [1:0]                         burst;
  logic                               write;
  logic [1:0]                         priv;
  logic [NR_ENTRIES-1:0][PMP_LEN-1:0] cfg_addr;
  logic [NR_ENTRIES-1:0][4:0]         cfg;        // {L, A[1:0], W, R}
  logic [PLEN-1:0]                    first_addr;
  logic [PLEN-1:0]                    last_addr;

  logic [15:0]      bytes;
  logic [15:0]      beat;
  logic [PLEN:0]    addr_ext;
  logic [PLEN:0]    beat_mask;
  logic [PLEN:0]    last_sum;
  logic [PLEN-1:0]  first_calc;
  logic             bad_burst;
  logic             calc_abort;

  logic [PMP_LEN-1:0] ent_addr;
  logic [PMP_LEN-1:0] ent_prev;
  logic [4:0]         ent_cfg;
  logic               ent_allow;
  logic               match_first;
  logic               match_last;
  logic               unused_cfg;

  assign unused_cfg = ^(conf_i & {NR_ENTRIES{8'b0110_0100}});

  // Burst footprint; last_sum carries one extra bit to catch wrap past the top of memory.
  always_comb begin
    bytes      = ({8'd0, len} + 16'd1) << size;
    beat       = 16'd1 << size;
    addr_ext   = {1'b0, addr};
    beat_mask  = ~((PLEN+1)'(beat) - (PLEN+1)'(1));
    first_calc = addr;
    last_sum   = '0;
    bad_burst  = 1'b0;
    case (burst)
      2'b00: last_sum = (addr_ext & beat_mask) + (PLEN+1)'(beat) - (PLEN+1)'(1);
      2'b01: last_sum = (addr_ext & beat_mask) + (PLEN+1)'(bytes) - (PLEN+1)'(1);
      2'b10: begin
        first_calc = addr & ~(PLEN'(bytes) - PLEN'(1));
        last_sum   = {1'b0, first_calc} + (PLEN+1)'(bytes) - (PLEN+1)'(1);
      end
      default: bad_burst = 1'b1;
    endcase
    calc_abort = bad_burst | last_sum[PLEN];
  end

  // Current entry's view; an unlocked entry never restricts M-mode.
  always_comb begin
    ent_addr = cfg_addr[idx];
    ent_cfg  = cfg[idx];
    if (idx == '0) begin
      ent_prev = '0;
    end else begin
      ent_prev = cfg_addr[idx - IW'(1)];
    end
    if ((priv == 2'b11) && !ent_cfg[4]) begin
      ent_allow = 1'b1;
    end else if (write) begin
      ent_allow = ent_cfg[1];
    end else begin
      ent_allow = ent_cfg[0];
    end
  end

  pmp_entry #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .PMPGranularity(PMPGranularity)) u_first (
    .addr_i           (first_addr),
    .conf_addr_i      (ent_addr),
    .conf_addr_prev_i (ent_prev),
    .conf_addr_mode_i (ent_cfg[3:2]),
    .match_o          (match_first)
  );

  pmp_entry #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .PMPGranularity(PMPGranularity)) u_last (
    .addr_i           (last_addr),
    .conf_addr_i      (ent_addr),
    .conf_addr_prev_i (ent_prev),
    .conf_addr_mode_i (ent_cfg[3:2]),
    .match_o          (match_last)
  );

  // Private copy of request and configuration, so later config writes cannot race the scan.
  always_ff @(posedge clk_i) begin
    if ((state == IDLE) && req_valid_i) begin
      addr     <= req_addr_i;
      len      <= req_len_i;
      size     <= req_size_i;
      burst    <= req_burst_i;
      write    <= req_write_i;
      priv     <= priv_lvl_i;
      cfg_addr <= conf_addr_i;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        cfg[i] <= {conf_i[i][7], conf_i[i][4:3], conf_i[i][1:0]};
      end
    end
    if (state == CALC) begin
      first_addr <= first_calc;
      last_addr  <= last_sum[PLEN-1:0];
    end
  end

  // Control FSM and registered response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_allow_o <= 1'b0;
      rsp_hit_o   <= 1'b0;
      rsp_entry_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            state       <= CALC;
            req_ready_o <= 1'b0;
          end
        end
        CALC: begin
          idx <= '0;
          if (calc_abort) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_allow_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_entry_o <= '0;
          end else begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (match_first || match_last) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_hit_o   <= 1'b1;
            rsp_entry_o <= idx;
            rsp_allow_o <= match_first && match_last && ent_allow;
          end else if (idx == IW'(NR_ENTRIES - 1)) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_hit_o   <= 1'b0;
            rsp_entry_o <= '0;
            rsp_allow_o <= (priv == 2'b11);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_allow_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_entry_o <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_io_pmp_burst_check.sv
// Scoreboard bench for io_pmp_burst_check: directed cases plus randomized bursts
// checked against a range-based reference model.

module tb_io_pmp_burst_check;
  localparam int PLEN    = 56;
  localparam int PMP_LEN = 54;
  localparam int NR      = 16;
  localparam int IW      = 4;

  logic                           clk;
  logic                           rst;
  logic                           req_valid;
  logic                           req_ready_o;
  logic [PLEN-1:0]                req_addr;
  logic [7:0]                     req_len;
  logic [2:0]                     req_size;
  logic [1:0]                     req_burst;
  logic                           req_write;
  logic [1:0]                     priv_lvl;
  logic [NR-1:0][PMP_LEN-1:0]     conf_addr;
  logic [NR-1:0][7:0]             conf;
  logic                           rsp_valid_o;
  logic                           rsp_ready_i;
  logic                           rsp_allow_o;
  logic                           rsp_hit_o;
  logic [IW-1:0]                  rsp_entry_o;

  typedef struct {
    logic allow;
    logic hit;
    int   entry;
    int   lat;
    int   acc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   passes   = 0;
  int   cyc      = 0;
  int   rsp_done = 0;
  bit   hold_low = 1'b0;

  io_pmp_burst_check #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR), .PMPGranularity(0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_size_i  (req_size),
    .req_burst_i (req_burst),
    .req_write_i (req_write),
    .priv_lvl_i  (priv_lvl),
    .conf_addr_i (conf_addr),
    .conf_i      (conf),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_allow_o (rsp_allow_o),
    .rsp_hit_o   (rsp_hit_o),
    .rsp_entry_o (rsp_entry_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Reference: region bounds as byte ranges, first/last byte by plain arithmetic.
  function automatic exp_t model(input logic [PLEN-1:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst,
                                 input logic wr, input logic [1:0] priv,
                                 input logic [NR-1:0][PMP_LEN-1:0] ca,
                                 input logic [NR-1:0][7:0] cf);
    exp_t e;
    longint unsigned a, bytes, beat, first, last, lo, hi, sz;
    int t;
    bit mf, ml;
    e.allow = 1'b0; e.hit = 1'b0; e.entry = 0; e.acc = 0; e.lat = 1;
    a     = 64'(addr);
    bytes = (64'(len) + 64'd1) << size;
    beat  = 64'd1 << size;
    first = a;
    last  = 64'd0;
    case (burst)
      2'd0: last = (a / beat) * beat + beat - 64'd1;
      2'd1: last = (a / beat) * beat + bytes - 64'd1;
      2'd2: begin first = (a / bytes) * bytes; last = first + bytes - 64'd1; end
      default: return e;
    endcase
    if (last >= (64'd1 << PLEN)) return e;
    for (int i = 0; i < NR; i++) begin
      lo = 64'd1; hi = 64'd0;
      case (cf[i][4:3])
        2'd1: begin
          if (i == 0) lo = 64'd0;
          else lo = 64'(ca[i-1]) * 64'd4;
          hi = 64'(ca[i]) * 64'd4;
        end
        2'd2: begin lo = 64'(ca[i]) * 64'd4; hi = lo + 64'd4; end
        2'd3: begin
          t = 0;
          while (t < PMP_LEN && ca[i][t]) t++;
          sz = 64'd1 << (t + 3);
          lo = ((64'(ca[i]) * 64'd4) / sz) * sz;
          hi = lo + sz;
        end
        default: ;
      endcase
      mf = (first >= lo) && (first < hi);
      ml = (last >= lo) && (last < hi);
      if (mf || ml) begin
        e.hit = 1'b1; e.entry = i; e.lat = i + 2;
        if (mf && ml) e.allow = (priv == 2'd3 && !cf[i][7]) ? 1'b1 : (wr ? cf[i][1] : cf[i][0]);
        return e;
      end
    end
    e.allow = (priv == 2'd3);
    e.lat   = NR + 1;
    return e;
  endfunction

  // Response acceptance is random unless a test holds it low.
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      rsp_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each new response and checks it every cycle it is held.
  initial begin
    exp_t cur;
    bit in_rsp, skip;
    in_rsp = 1'b0; skip = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp = 1'b0;
      end else if (rsp_valid_o) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          if (sbq.size() == 0) begin
            skip = 1'b1;
            checks++;
            $display("FAIL unexpected_rsp: rsp_valid_o=1 with nothing outstanding, required 0");
          end else begin
            skip = 1'b0;
            cur  = sbq.pop_front();
            chk("latency", cyc - cur.acc, cur.lat);
          end
        end
        if (!skip) begin
          chk("allow", rsp_allow_o, cur.allow);
          chk("hit", rsp_hit_o, cur.hit);
          chk("entry", rsp_entry_o, cur.entry);
        end
        chk("req_ready_in_resp", req_ready_o, 0);
        if (rsp_ready_i) begin
          in_rsp = 1'b0;
          rsp_done++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic clear_cfg();
    conf      = '0;
    conf_addr = '0;
  endtask

  task automatic rand_cfg();
    int t, m;
    for (int i = 0; i < NR; i++) begin
      m = $urandom_range(0, 3);
      conf[i] = {($urandom_range(0, 3) == 0), 2'($urandom), 2'(m), 1'($urandom), 1'($urandom), 1'($urandom)};
      if (m == 3) begin
        t = $urandom_range(0, 10);
        conf_addr[i] = PMP_LEN'(64'h2000_0000 + (64'($urandom_range(0, 15)) << (t + 1)) + ((64'd1 << t) - 64'd1));
      end else begin
        conf_addr[i] = PMP_LEN'(64'h2000_0000 + 64'($urandom_range(0, 16'h4000)));
      end
    end
  endtask

  task automatic issue(input logic [PLEN-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic wr, input logic [1:0] priv,
                       input bit push, input bit wait_done, input bit directed, input exp_t dexp,
                       input string name);
    exp_t e;
    int n, start;
    @(negedge clk);
    n = 0;
    while (!req_ready_o && n < 300) begin @(negedge clk); n++; end
    if (!req_ready_o) begin chk({name, "_ready"}, req_ready_o, 1); return; end
    e = directed ? dexp : model(addr, len, size, burst, wr, priv, conf_addr, conf);
    req_addr = addr; req_len = len; req_size = size; req_burst = burst;
    req_write = wr; priv_lvl = priv; req_valid = 1'b1;
    start = rsp_done;
    @(posedge clk); #1;
    e.acc = cyc;
    if (push) sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < NR; i++) begin
      conf_addr[i] = PMP_LEN'({$urandom, $urandom});
      conf[i]      = 8'($urandom);
    end
    if (wait_done) begin
      n = 0;
      while (rsp_done == start && n < 300) begin @(negedge clk); n++; end
      chk({name, "_done"}, (rsp_done != start), 1);
    end
  endtask

  initial begin
    exp_t d;
    int n, start;
    logic [PLEN-1:0] a;
    logic [1:0] b;
    logic [7:0] l;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
    req_burst = '0; req_write = 1'b0; priv_lvl = '0;
    clear_cfg();
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_allow", rsp_allow_o, 0);
    chk("rst_hit", rsp_hit_o, 0);
    chk("rst_entry", rsp_entry_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    rst = 1'b0;

    clear_cfg(); conf_addr[0] = PMP_LEN'(64'h2000_01FF); conf[0] = 8'h19;
    d = '{allow: 1'b1, hit: 1'b1, entry: 0, lat: 2, acc: 0};
    issue(56'h8000_0000, 8'd3, 3'd3, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, d, "napot_read");

    clear_cfg(); conf_addr[0] = PMP_LEN'(64'h2000_01FF); conf[0] = 8'h19;
    d = '{allow: 1'b0, hit: 1'b1, entry: 0, lat: 2, acc: 0};
    issue(56'h8000_0FF8, 8'd1, 3'd3, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, d, "straddle");

    clear_cfg(); conf_addr[0] = PMP_LEN'(64'h2000_0000); conf_addr[1] = PMP_LEN'(64'h2000_0400); conf[1] = 8'h08;
    d = '{allow: 1'b0, hit: 1'b1, entry: 1, lat: 3, acc: 0};
    issue(56'h8000_0100, 8'd0, 3'd2, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, d, "tor_prio");

    clear_cfg();
    d = '{allow: 1'b0, hit: 1'b0, entry: 0, lat: NR + 1, acc: 0};
    issue(56'h8000_0100, 8'd0, 3'd2, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, d, "nomatch_u");
    clear_cfg();
    d = '{allow: 1'b1, hit: 1'b0, entry: 0, lat: NR + 1, acc: 0};
    issue(56'h8000_0100, 8'd0, 3'd2, 2'd1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, d, "nomatch_m");

    clear_cfg(); conf_addr[0] = PMP_LEN'(64'h2000_01FF); conf[0] = 8'h19;
    d = '{allow: 1'b1, hit: 1'b1, entry: 0, lat: 2, acc: 0};
    issue(56'h8000_0000, 8'd0, 3'd2, 2'd1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, d, "m_unlocked");
    clear_cfg(); conf_addr[0] = PMP_LEN'(64'h2000_01FF); conf[0] = 8'h99;
    d = '{allow: 1'b0, hit: 1'b1, entry: 0, lat: 2, acc: 0};
    issue(56'h8000_0000, 8'd0, 3'd2, 2'd1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, d, "m_locked");

    clear_cfg();
    d = '{allow: 1'b0, hit: 1'b0, entry: 0, lat: 1, acc: 0};
    issue(56'hFF_FFFF_FFFF_FFF0, 8'd3, 3'd3, 2'd1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, d, "top_carry");
    issue(56'h1000, 8'd0, 3'd2, 2'd3, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, d, "reserved_burst");

    // Reset in the middle of a scan must drop the transaction silently.
    clear_cfg();
    issue(56'h8000_0100, 8'd0, 3'd2, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, d, "rst_scan");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_scan_valid", rsp_valid_o, 0);
    chk("rst_scan_ready", req_ready_o, 1);
    repeat (NR + 4) @(negedge clk);
    chk("rst_scan_quiet", rsp_valid_o, 0);

    // Back-pressure: response held for 5 cycles with outputs stable.
    clear_cfg(); conf_addr[0] = PMP_LEN'(64'h2000_01FF); conf[0] = 8'h19;
    d = '{allow: 1'b1, hit: 1'b1, entry: 0, lat: 2, acc: 0};
    hold_low = 1'b1;
    start = rsp_done;
    issue(56'h8000_0000, 8'd3, 3'd3, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, d, "hold");
    n = 0;
    while (!rsp_valid_o && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_ready", req_ready_o, 0);
      @(negedge clk);
    end
    hold_low = 1'b0;
    n = 0;
    while (rsp_done == start && n < 50) begin @(negedge clk); n++; end
    chk("hold_done", (rsp_done != start), 1);

    for (int it = 0; it < 250; it++) begin
      rand_cfg();
      if ($urandom_range(0, 7) == 0) a = 56'hFF_FFFF_FFFF_FFFF - 56'($urandom_range(0, 300));
      else a = 56'h8000_0000 + 56'($urandom_range(0, 32'h1_0000));
      b = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) b = 2'd3;
      l = 8'($urandom_range(0, 15));
      if (b == 2'd2) l = 8'((1 << $urandom_range(1, 4)) - 1);
      else if ($urandom_range(0, 15) == 0) l = 8'd255;
      issue(a, l, 3'($urandom_range(0, 7)), b, 1'($urandom),
            ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1)),
            1'b1, 1'b1, 1'b0, d, "rand");
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/io_pmp_burst_check.md
Name: io_pmp_burst_check

Overview:
- Sequential PMP checker for AXI bursts, upstream consumer of per-entry matching in the IO-PMP.
- Accepts one transaction descriptor, derives the first and last byte of the burst, and scans PMP entries lowest index first.
- Uses two internal pmp_entry instances, one for the first byte and one for the last byte, sharing one entry's config per cycle.
- Returns allow/deny plus the deciding entry index to the AXI gating logic.

Parameters:
- PLEN, 56: physical address width.
- PMP_LEN, 54: pmpaddr register width.
- NR_ENTRIES, 16: number of PMP entries (2..64).
- PMPGranularity, 0: forwarded to pmp_entry; same encoding as pmp_entry.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_addr_i  in  PLEN  AXI AxADDR.
- req_len_i  in  8  AXI AxLEN.
- req_size_i  in  3  AXI AxSIZE.
- req_burst_i  in  2  AXI AxBURST: 0 FIXED, 1 INCR, 2 WRAP.
- req_write_i  in  1  1=write, 0=read.
- priv_lvl_i  in  2  privilege of the initiator; 2'b11 = M.
- conf_addr_i  in  NR_ENTRIES x PMP_LEN  pmpaddr array.
- conf_i  in  NR_ENTRIES x 8  pmpcfg bytes: [0] R, [1] W, [4:3] A, [7] L.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result accepted.
- rsp_allow_o  out  1  access permitted.
- rsp_hit_o  out  1  some entry decided the result.
- rsp_entry_o  out  $clog2(NR_ENTRIES)  deciding entry index; 0 when rsp_hit_o=0.

Behaviour:
- Reset values:
  - rsp_valid_o=0, rsp_allow_o=0, rsp_hit_o=0, rsp_entry_o=0.
  - req_ready_o=1; state IDLE; scan index 0.
- FSM states: IDLE, CALC, SCAN, RESP.
- IDLE:
  - req_ready_o=1 only in IDLE.
  - On req_valid_i, latch all req_* fields, priv_lvl_i, conf_addr_i and conf_i, then go to CALC.
  - Config changes after acceptance do not affect the transaction in flight.
- CALC (1 cycle): compute first/last byte with bytes=(len+1)<<size and beat=1<<size.
  - FIXED: first=addr, last=(addr & ~(beat-1))+beat-1.
  - INCR: first=addr, last=(addr & ~(beat-1))+bytes-1.
  - WRAP: first=addr & ~(bytes-1), last=first+bytes-1.
  - Burst type 3 (reserved), or a carry out of bit PLEN-1 in the last-byte sum: go directly to RESP with allow=0, hit=0.
  - Otherwise go to SCAN with index 0.
- SCAN (1 entry per cycle):
  - Both pmp_entry instances get conf_addr[idx], mode conf[idx][4:3], and prev = (idx==0 ? 0 : conf_addr[idx-1]).
  - Both match: hit=1, entry=idx, go to RESP.
    - allow = (priv==M && !L) ? 1 : (write ? W : R).
  - Exactly one matches (burst straddles a region boundary): hit=1, entry=idx, allow=0, go to RESP.
  - Neither matches and idx<NR_ENTRIES-1: idx++.
  - Neither matches and idx==NR_ENTRIES-1: hit=0, entry=0, allow=(priv==M), go to RESP.
- RESP:
  - rsp_valid_o=1 with outputs held stable until rsp_ready_i.
  - On handshake: rsp_valid_o drops next cycle, state returns to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency: request accepted at cycle T, deciding entry k gives rsp_valid_o at T+k+3.
  - Early termination in CALC gives rsp_valid_o at T+2.
- Reset asserted in any state: next cycle is IDLE with reset values; the in-flight transaction is dropped and no response is produced.
- OFF entries never match. NA4 with PMPGranularity>0 never matches, as inside pmp_entry.

Test Plan:
- NAPOT hit, allowed read:
  - Setup: entry0 conf_addr=0x200001FF (4 KiB at 0x8000_0000), cfg R=1 A=NAPOT.
  - Stimulus: INCR read, addr 0x8000_0000, len=3, size=3, U-mode.
  - Required: allow=1, hit=1, entry=0, rsp_valid at T+3.
- Straddle: same config, INCR read at 0x8000_0FF8, len=1, size=3 (last byte 0x8000_1007) -> allow=0, hit=1, entry=0.
- Priority and TOR:
  - Setup: entry0 OFF, conf_addr[0]=0x2000_0000; entry1 TOR, conf_addr[1]=0x2000_0400, R=0.
  - Stimulus: read at 0x8000_0100, len=0, size=2.
  - Required: allow=0, hit=1, entry=1, rsp_valid at T+4.
- No match, all entries OFF:
  - U-mode read -> allow=0, hit=0 at T+NR_ENTRIES+2.
  - Same read in M-mode -> allow=1, hit=0.
- Lock semantics:
  - M-mode write into entry0 with W=0, L=0 -> allow=1.
  - Same write with L=1 -> allow=0.
- Edge cases:
  - INCR at addr = 2^PLEN-16, len=3, size=3 -> allow=0, hit=0 at T+2.
  - Reset pulsed during SCAN -> no rsp_valid, req_ready_o=1 next cycle.
  - rsp_ready_i held low for 5 cycles -> outputs stable; req_ready_o stays 0 throughout.
